// File: rtl/odd_parity_serial_tx_if.sv
// Parallel word handshake between a producer and the odd-parity serial transmitter.
// The producer drives in_valid/in_data and holds them until it sees in_ready.
interface odd_parity_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/odd_parity_serial_tx.sv
// Serialises one accepted word per frame: start bit, data LSB first, odd parity bit, stop bit.
// Every output is a register loaded from the next-state decode, so tx is glitch-free.
module odd_parity_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  odd_parity_serial_tx_if.slave  s_if,
  output logic                   tx,
  output logic                   busy,
  output logic                   parity_out,
  output logic                   frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cyc, w_cyc_nxt;
  logic [BW-1:0]     r_bit, w_bit_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_tx, r_busy, r_in_ready, r_parity, r_frame_done;
  logic              w_tx_nxt, w_parity_nxt, w_frame_done_nxt;
  logic              w_accept, w_cyc_end;

  assign w_accept  = s_if.in_valid & r_in_ready;
  assign w_cyc_end = (r_cyc == CNT_MAX);

  // State register: control state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cyc        <= '0;
      r_bit        <= '0;
      r_tx         <= 1'b1;
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_parity     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cyc        <= w_cyc_nxt;
      r_bit        <= w_bit_nxt;
      r_tx         <= w_tx_nxt;
      r_in_ready   <= (w_state_nxt == IDLE);
      r_busy       <= (w_state_nxt != IDLE);
      r_parity     <= w_parity_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Data path register: the shift register carries payload only and needs no reset
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt  = r_state;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt  = START;
          w_bit_nxt    = '0;
          w_shift_nxt  = s_if.in_data;
          w_parity_nxt = ~^s_if.in_data;
        end
      end
      START:  if (w_cyc_end) w_state_nxt = DATA;
      DATA: begin
        if (w_cyc_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BIT_MAX) begin
            w_state_nxt = PARITY;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end
      end
      PARITY: if (w_cyc_end) w_state_nxt = STOP;
      STOP:   if (w_cyc_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    if (r_state == IDLE || w_state_nxt != r_state || w_cyc_end) w_cyc_nxt = '0;
    else                                                         w_cyc_nxt = r_cyc + CW'(1);
  end

  // Output decode from the upcoming state, captured by the output registers
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      IDLE:    w_tx_nxt = 1'b1;
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = w_parity_nxt;
      STOP:    w_tx_nxt = 1'b1;
      default: w_tx_nxt = 1'b1;
    endcase
    w_frame_done_nxt = (w_state_nxt == STOP) && (w_cyc_nxt == CNT_MAX);
  end

  assign s_if.in_ready = r_in_ready;
  assign tx            = r_tx;
  assign busy          = r_busy;
  assign parity_out    = r_parity;
  assign frame_done    = r_frame_done;

endmodule
